main_memory: RTL and testbench

- Behavioural main-memory responder: the target end of the L2's memory request channel (mem_req_* / mem_resp_*).
- Accepts one line-granular read or write at a time and holds a flop-based backing store (2^MEM_ADDR_W lines).
- Returns exactly one response pulse per request after a fixed, parameterised latency.
- Used in system integration and L2 verification in place of real DRAM.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/main_memory_array.sv | 35 +++
 rtl/main_memory.sv | 137 +++++++++++++
 tb/tb_main_memory.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache/memory protocol definitions: geometry constants, the memory
// responder state encoding and the request bus typedefs.
package cache_pkg;

    localparam int ADDR_BITS      = 12;
    localparam int OFFSET_BITS    = 6;
    localparam int CACHELINE_BITS = 1;
    localparam int LINE_ADDR_BITS = ADDR_BITS - OFFSET_BITS;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic                      valid;
        logic                      rw;
        logic [LINE_ADDR_BITS-1:0] addr;
        logic [CACHELINE_BITS-1:0] data;
    } bus_req_t;

    typedef struct packed {
        logic                      valid;
        logic [CACHELINE_BITS-1:0] data;
    } bus_resp_t;

endpackage

// File: rtl/main_memory_array.sv
// Flop-based backing store: one synchronous write port, one combinational
// read port, every line reset asynchronously to INIT_VAL.
module main_memory_array
    import cache_pkg::*;
#(
    parameter int                ADDR_W   = LINE_ADDR_BITS,
    parameter int                DATA_W   = CACHELINE_BITS,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT_VAL;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/main_memory.sv
// Main-memory responder for the L2 memory channel: one outstanding
// line request, fixed read/write latency, single-cycle response pulse.
module main_memory
    import cache_pkg::*;
#(
    parameter int                MEM_ADDR_W = LINE_ADDR_BITS,
    parameter int                LINE_W     = CACHELINE_BITS,
    parameter int                RD_LAT     = 4,
    parameter int                WR_LAT     = 2,
    parameter logic [LINE_W-1:0] INIT_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_req_valid,
    input  logic                  mem_req_rw,
    input  logic [MEM_ADDR_W-1:0] mem_req_addr,
    input  logic [LINE_W-1:0]     mem_req_data,
    output logic                  mem_req_ready,
    output logic                  mem_resp_valid,
    output logic [LINE_W-1:0]     mem_resp_data,
    output logic [15:0]           stat_reads,
    output logic [15:0]           stat_writes
);

    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
        $error("main_memory: RD_LAT must be within 1..15");
    end
    if (WR_LAT < 1 || WR_LAT > 15) begin : g_bad_wr_lat
        $error("main_memory: WR_LAT must be within 1..15");
    end

    localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

    mem_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rw_q;
    logic [MEM_ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0]     data_q;
    logic                  ready_q, ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [LINE_W-1:0]     resp_data_q, resp_data_d;
    logic [15:0]           reads_q, writes_q;

    logic                  hs;
    logic                  eff_rw;
    logic [MEM_ADDR_W-1:0] eff_addr;
    logic [LINE_W-1:0]     eff_data;
    logic                  we;
    logic [LINE_W-1:0]     rdata;

    // A zero-latency load enters RESP on the handshake edge itself, so the
    // store and the response must see the live request, not the capture.
    assign hs       = (state_q == IDLE) && mem_req_valid;
    assign eff_rw   = hs ? mem_req_rw   : rw_q;
    assign eff_addr = hs ? mem_req_addr : addr_q;
    assign eff_data = hs ? mem_req_data : data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: state_d = IDLE;
            IDLE: begin
                if (hs) begin
                    cnt_d   = mem_req_rw ? WR_CNT : RD_CNT;
                    state_d = (cnt_d == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign we           = (state_d == RESP) && eff_rw;
    assign ready_d      = (state_d == IDLE);
    assign resp_valid_d = (state_d == RESP);
    assign resp_data_d  = (state_d == RESP) ? (eff_rw ? eff_data : rdata) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= INIT;
            cnt_q        <= 4'd0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            reads_q      <= 16'd0;
            writes_q     <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            if (hs && mem_req_rw) begin
                writes_q <= writes_q + 16'd1;
            end
            if (hs && !mem_req_rw) begin
                reads_q <= reads_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            rw_q   <= mem_req_rw;
            addr_q <= mem_req_addr;
            data_q <= mem_req_data;
        end
    end

    main_memory_array #(
        .ADDR_W   (MEM_ADDR_W),
        .DATA_W   (LINE_W),
        .INIT_VAL (INIT_VAL)
    ) u_array (
        .clk     (clk),
        .rst_ni  (reset_n),
        .we_i    (we),
        .waddr_i (eff_addr),
        .wdata_i (eff_data),
        .raddr_i (eff_addr),
        .rdata_o (rdata)
    );

    assign mem_req_ready  = ready_q;
    assign mem_resp_valid = resp_valid_q;
    assign mem_resp_data  = resp_data_q;
    assign stat_reads     = reads_q;
    assign stat_writes    = writes_q;

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: two instances (latencies 4/2 and 1/1) driven by
// directed and random requests, compared every cycle against a memory model.
module tb_main_memory;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid  [2];
    logic       req_rw     [2];
    logic [5:0] req_addr   [2];
    logic       req_data   [2];
    logic       req_ready  [2];
    logic       resp_valid [2];
    logic       resp_data  [2];
    logic [15:0] st_rd     [2];
    logic [15:0] st_wr     [2];

    int nchecks = 0;
    int nerrors = 0;

    int cyc = 0;
    int avail    [2];
    int resp_cyc [2];
    logic exp_data [2];
    logic mem_m [2][64];
    int rd_cnt [2];
    int wr_cnt [2];
    int npulse [2];
    int lat_rd [2] = '{4, 1};
    int lat_wr [2] = '{2, 1};

    always #5 clk = ~clk;

    main_memory #(.MEM_ADDR_W(6), .LINE_W(1), .RD_LAT(4), .WR_LAT(2), .INIT_VAL(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .mem_req_valid(req_valid[0]), .mem_req_rw(req_rw[0]),
        .mem_req_addr(req_addr[0]), .mem_req_data(req_data[0]),
        .mem_req_ready(req_ready[0]), .mem_resp_valid(resp_valid[0]),
        .mem_resp_data(resp_data[0]), .stat_reads(st_rd[0]), .stat_writes(st_wr[0])
    );

    main_memory #(.MEM_ADDR_W(6), .LINE_W(1), .RD_LAT(1), .WR_LAT(1), .INIT_VAL(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .mem_req_valid(req_valid[1]), .mem_req_rw(req_rw[1]),
        .mem_req_addr(req_addr[1]), .mem_req_data(req_data[1]),
        .mem_req_ready(req_ready[1]), .mem_resp_valid(resp_valid[1]),
        .mem_resp_data(resp_data[1]), .stat_reads(st_rd[1]), .stat_writes(st_wr[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a request is accepted whenever valid is high and the
    // previous one has fully retired; its response is due LAT cycles later.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                for (int a = 0; a < 64; a++) mem_m[k][a] = 1'b0;
                rd_cnt[k]   = 0;
                wr_cnt[k]   = 0;
                resp_cyc[k] = -1;
                avail[k]    = cyc + 2;
            end else if (req_valid[k] && cyc >= avail[k]) begin
                if (req_rw[k]) begin
                    mem_m[k][req_addr[k]] = req_data[k];
                    exp_data[k] = req_data[k];
                    wr_cnt[k]++;
                    resp_cyc[k] = cyc + lat_wr[k];
                    avail[k]    = cyc + lat_wr[k] + 1;
                end else begin
                    exp_data[k] = mem_m[k][req_addr[k]];
                    rd_cnt[k]++;
                    resp_cyc[k] = cyc + lat_rd[k];
                    avail[k]    = cyc + lat_rd[k] + 1;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                chk($sformatf("m%0d_rst_ready", k), req_ready[k], 0);
                chk($sformatf("m%0d_rst_valid", k), resp_valid[k], 0);
                chk($sformatf("m%0d_rst_data", k), resp_data[k], 0);
                chk($sformatf("m%0d_rst_reads", k), st_rd[k], 0);
                chk($sformatf("m%0d_rst_writes", k), st_wr[k], 0);
            end else begin
                chk($sformatf("m%0d_ready", k), req_ready[k], cyc >= avail[k]);
                chk($sformatf("m%0d_valid", k), resp_valid[k], cyc == resp_cyc[k]);
                chk($sformatf("m%0d_data", k), resp_data[k], (cyc == resp_cyc[k]) ? exp_data[k] : 1'b0);
                chk($sformatf("m%0d_reads", k), st_rd[k], 16'(rd_cnt[k]));
                chk($sformatf("m%0d_writes", k), st_wr[k], 16'(wr_cnt[k]));
            end
            if (resp_valid[k]) npulse[k]++;
        end
    end

    // Entered and left just after a rising edge; holds valid until accepted.
    task automatic issue(input int k, input logic rw, input logic [5:0] a,
                         input logic d, input logic keep);
        int t;
        req_valid[k] = 1'b1;
        req_rw[k]    = rw;
        req_addr[k]  = a;
        req_data[k]  = d;
        t = 0;
        @(negedge clk);
        while (!req_ready[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            nchecks++;
            nerrors++;
            $display("FAIL m%0d_handshake_timeout: ready stayed 0, expected 1 within 50 cycles", k);
        end
        @(posedge clk);
        #1;
        if (!keep) req_valid[k] = 1'b0;
    endtask

    task automatic lat_check(input int k, input int lat, input logic d);
        for (int i = 1; i <= lat + 1; i++) begin
            @(negedge clk);
            chk($sformatf("m%0d_lat_valid_c%0d", k, i), resp_valid[k], i == lat);
            chk($sformatf("m%0d_lat_ready_c%0d", k, i), req_ready[k], i == lat + 1);
            chk($sformatf("m%0d_lat_data_c%0d", k, i), resp_data[k], (i == lat) ? d : 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops(input int k, input int n);
        logic       rw;
        logic [5:0] a;
        logic       d;
        for (int i = 0; i < n; i++) begin
            rw = 1'($urandom_range(0, 1));
            a  = (i % 3 == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 63));
            d  = 1'($urandom_range(0, 1));
            issue(k, rw, a, d, 1'b1);
            if ($urandom_range(0, 7) == 0) begin
                req_valid[k] = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        req_valid[k] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, c1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_rw[k]    = 1'b0;
            req_addr[k]  = '0;
            req_data[k]  = 1'b0;
            npulse[k]    = 0;
            avail[k]     = 0;
            resp_cyc[k]  = -1;
        end

        // Reset release
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_ready_first", req_ready[0], 0);
        @(negedge clk);
        chk("rel_ready_second", req_ready[0], 1);
        chk("rel_reads", st_rd[0], 0);
        chk("rel_writes", st_wr[0], 0);
        @(posedge clk);
        #1;

        // Cold read, then the 1-cycle latency corner
        issue(0, 1'b0, 6'h2A, 1'b0, 1'b0);
        lat_check(0, 4, 1'b0);
        @(negedge clk);
        chk("cold_reads", st_rd[0], 1);
        @(posedge clk);
        #1;
        issue(1, 1'b1, 6'h07, 1'b1, 1'b0);
        lat_check(1, 1, 1'b1);
        issue(1, 1'b0, 6'h07, 1'b0, 1'b0);
        lat_check(1, 1, 1'b1);

        // Write then read back
        do_reset();
        issue(0, 1'b1, 6'h3F, 1'b1, 1'b0);
        lat_check(0, 2, 1'b1);
        issue(0, 1'b0, 6'h3F, 1'b0, 1'b0);
        lat_check(0, 4, 1'b1);
        issue(0, 1'b0, 6'h3E, 1'b0, 1'b0);
        lat_check(0, 4, 1'b0);
        @(negedge clk);
        chk("wr_rd_writes", st_wr[0], 1);
        chk("wr_rd_reads", st_rd[0], 2);
        @(posedge clk);
        #1;

        // Valid held high across a busy write
        p0 = npulse[0];
        issue(0, 1'b1, 6'h10, 1'b1, 1'b1);
        req_rw[0] = 1'b0;
        c1 = cyc;
        issue(0, 1'b0, 6'h10, 1'b0, 1'b0);
        chk("held_gap", cyc - c1, 3);
        repeat (6) @(posedge clk);
        #1;
        chk("held_pulses", npulse[0] - p0, 2);

        // Reset during WAIT of a write
        p0 = npulse[0];
        issue(0, 1'b1, 6'h05, 1'b1, 1'b0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_pulses", npulse[0] - p0, 0);
        issue(0, 1'b0, 6'h05, 1'b0, 1'b0);
        lat_check(0, 4, 1'b0);
        @(negedge clk);
        chk("midrst_writes", st_wr[0], 0);
        chk("midrst_reads", st_rd[0], 1);
        @(posedge clk);
        #1;

        // Random traffic on both instances
        fork
            rand_ops(0, 1000);
            rand_ops(1, 1000);
        join
        repeat (10) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
